// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store width
// codes and the transaction FSM states used by the datapath and testbench.
package dmem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for RV32I sub-word accesses: store byte
// enables and replicated write data, sign/zero-extended load data, error flag.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic        write,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] ram_word,
  output logic [3:0]  byte_en,
  output logic [31:0] write_word,
  output logic [31:0] rdata,
  output logic        err
);

  logic       legal;
  logic       misaligned;
  logic [7:0] load_byte;
  logic [15:0] load_half;

  // Unsigned widths exist only for loads, so they are illegal as store codes.
  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      F3_B:  legal = 1'b1;
      F3_H:  begin legal = 1'b1;   misaligned = addr[0];        end
      F3_W:  begin legal = 1'b1;   misaligned = (addr != 2'b00); end
      F3_BU: legal = !write;
      F3_HU: begin legal = !write; misaligned = addr[0];        end
      default: legal = 1'b0;
    endcase
    err = !legal || misaligned;
  end

  assign load_byte = ram_word[{addr, 3'b000} +: 8];
  assign load_half = addr[1] ? ram_word[31:16] : ram_word[15:0];

  always_comb begin
    byte_en    = 4'b0000;
    write_word = 32'd0;
    rdata      = 32'd0;
    if (!err) begin
      case (funct3)
        F3_B, F3_BU: begin
          byte_en    = 4'b0001 << addr;
          write_word = {4{wdata[7:0]}};
          rdata      = (funct3 == F3_B) ? {{24{load_byte[7]}}, load_byte}
                                        : {24'd0, load_byte};
        end
        F3_H, F3_HU: begin
          byte_en    = addr[1] ? 4'b1100 : 4'b0011;
          write_word = {2{wdata[15:0]}};
          rdata      = (funct3 == F3_H) ? {{16{load_half[15]}}, load_half}
                                        : {16'd0, load_half};
        end
        default: begin
          byte_en    = 4'b1111;
          write_word = wdata;
          rdata      = ram_word;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM serving RV32I loads/stores over
// valid/ready request and response channels with LATENCY wait cycles.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int DEPTH = 2 ** (DM_ADDRESS - 2);

  state_t                  state, state_next;
  logic [2:0]              cnt, cnt_next;
  logic                    accept, commit;

  logic                    lat_write;
  logic [DM_ADDRESS-1:0]   lat_addr;
  logic [DATA_W-1:0]       lat_wdata;
  logic [2:0]              lat_funct3;

  logic                    cur_write;
  logic [DM_ADDRESS-1:0]   cur_addr;
  logic [DATA_W-1:0]       cur_wdata;
  logic [2:0]              cur_funct3;

  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DATA_W-1:0]       ram_word;
  logic [3:0]              byte_en;
  logic [DATA_W-1:0]       write_word;
  logic [DATA_W-1:0]       load_data;
  logic                    align_err;

  logic [DATA_W-1:0]       rdata_q;
  logic                    err_q;

  // With zero latency the commit coincides with acceptance, so the live
  // request is used before it has been latched.
  assign cur_write  = (state == IDLE) ? req_write  : lat_write;
  assign cur_addr   = (state == IDLE) ? req_addr   : lat_addr;
  assign cur_wdata  = (state == IDLE) ? req_wdata  : lat_wdata;
  assign cur_funct3 = (state == IDLE) ? req_funct3 : lat_funct3;

  assign ram_word = mem[cur_addr[DM_ADDRESS-1:2]];

  dmem_lane_align u_align (
    .write      (cur_write),
    .addr       (cur_addr[1:0]),
    .funct3     (cur_funct3),
    .wdata      (cur_wdata),
    .ram_word   (ram_word),
    .byte_en    (byte_en),
    .write_word (write_word),
    .rdata      (load_data),
    .err        (align_err)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept   = 1'b1;
          cnt_next = 3'(LATENCY);
          if (LATENCY == 0) begin
            commit     = 1'b1;
            state_next = RESP;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 3'd1) begin
          commit     = 1'b1;
          cnt_next   = 3'd0;
          state_next = RESP;
        end else begin
          cnt_next = cnt - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_funct3 <= 3'd0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        lat_write  <= req_write;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
        lat_funct3 <= req_funct3;
      end
      if (commit) begin
        err_q   <= align_err;
        rdata_q <= (cur_write || align_err) ? '0 : load_data;
      end
    end
  end

  // RAM is deliberately left out of reset; reset drops state so no commit fires.
  always_ff @(posedge clk) begin
    if (commit && cur_write && !align_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[cur_addr[DM_ADDRESS-1:2]][b*8 +: 8] <= write_word[b*8 +: 8];
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
